// File: rtl/execute_pipe_if.sv
// Signal bundle between the E register, the execute stage and the M register.
// The master side drives E-stage operands and pipeline control; the slave side is the execute stage.
interface execute_pipe_if #(
    parameter int WIDTH = 64
);
    logic [2:0]       E_stat;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valA;
    logic [WIDTH-1:0] E_valB;
    logic [WIDTH-1:0] E_valC;
    logic [3:0]       E_dstE;
    logic [3:0]       E_dstM;
    logic             m_bad;
    logic             W_bad;
    logic             M_stall;
    logic             M_bubble;

    logic [WIDTH-1:0] e_valE;
    logic [3:0]       e_dstE;
    logic [2:0]       cc;
    logic [2:0]       M_stat;
    logic [3:0]       M_icode;
    logic             M_Cnd;
    logic [WIDTH-1:0] M_valE;
    logic [WIDTH-1:0] M_valA;
    logic [3:0]       M_dstE;
    logic [3:0]       M_dstM;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output m_bad, W_bad, M_stall, M_bubble,
        input  e_valE, e_dstE, cc, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  m_bad, W_bad, M_stall, M_bubble,
        output e_valE, e_dstE, cc, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_pipe.sv
// Y86-64 PIPE execute stage: ALU, condition codes, branch/cmov condition and the E->M register.
// e_valE/e_dstE are combinational for forwarding; everything on M_* and cc is registered.
module execute_pipe #(
    parameter int WIDTH      = 64,
    parameter int EXT_ALU    = 0,
    parameter int STACK_STEP = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    execute_pipe_if.slave p
);
    localparam int               SHW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] NEGSTEP = '0 - STEP;
    localparam logic [2:0]       S_AOK   = 3'd1;
    localparam logic [2:0]       S_INS   = 3'd4;
    localparam logic [3:0]       I_NOP   = 4'h1;
    localparam logic [3:0]       RNONE   = 4'hF;

    logic [WIDTH-1:0] alu_a, alu_b, sum, diff, res;
    logic [3:0]       alu_fun;
    logic             is_op, ifun_ok, op_bad, set_cc;
    logic             zf, sf, of, cond, cnd;
    logic [3:0]       dste_eff;
    logic [2:0]       stat_eff;

    logic [2:0]       cc_q;
    logic [2:0]       m_stat_q;
    logic [3:0]       m_icode_q;
    logic             m_cnd_q;
    logic [WIDTH-1:0] m_vale_q;
    logic [WIDTH-1:0] m_vala_q;
    logic [3:0]       m_dste_q;
    logic [3:0]       m_dstm_q;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (p.E_icode)
            4'h2, 4'h6:       alu_a = p.E_valA;
            4'h3, 4'h4, 4'h5: alu_a = p.E_valC;
            4'h8, 4'hA:       alu_a = NEGSTEP;
            4'h9, 4'hB:       alu_a = STEP;
            default:          alu_a = '0;
        endcase
        case (p.E_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = p.E_valB;
            default:                                  alu_b = '0;
        endcase
    end

    assign is_op   = (p.E_icode == 4'h6);
    assign ifun_ok = (EXT_ALU != 0) ? (p.E_ifun <= 4'd5) : (p.E_ifun <= 4'd3);
    assign op_bad  = is_op && !ifun_ok;
    assign alu_fun = is_op ? p.E_ifun : 4'd0;
    assign sum     = alu_b + alu_a;
    assign diff    = alu_b - alu_a;

    always_comb begin
        res = '0;
        of  = 1'b0;
        case (alu_fun)
            4'd0: begin
                res = sum;
                of  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            4'd1: begin
                res = diff;
                of  = (alu_b[WIDTH-1] != alu_a[WIDTH-1]) && (diff[WIDTH-1] != alu_b[WIDTH-1]);
            end
            4'd2:    res = alu_b & alu_a;
            4'd3:    res = alu_b ^ alu_a;
            4'd4:    res = alu_b | alu_a;
            4'd5:    res = alu_b << alu_a[SHW-1:0];
            default: res = '0;
        endcase
        // Unsupported OPq codes yield zero; set_cc is also blocked for them below.
        if (op_bad) begin
            res = '0;
            of  = 1'b0;
        end
    end

    assign zf     = (res == '0);
    assign sf     = res[WIDTH-1];
    assign set_cc = is_op && ifun_ok && !p.m_bad && !p.W_bad && (p.E_stat == S_AOK);

    // cc_q = {ZF,SF,OF}; conditions read the value before this cycle's update.
    always_comb begin
        cond = 1'b0;
        case (p.E_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'd2:    cond = cc_q[1] ^ cc_q[0];
            4'd3:    cond = cc_q[2];
            4'd4:    cond = !cc_q[2];
            4'd5:    cond = !(cc_q[1] ^ cc_q[0]);
            4'd6:    cond = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
            default: cond = 1'b0;
        endcase
    end

    assign cnd      = ((p.E_icode == 4'h2) || (p.E_icode == 4'h7)) && cond;
    assign dste_eff = ((p.E_icode == 4'h2) && !cnd) ? RNONE : p.E_dstE;
    assign stat_eff = (op_bad && (p.E_stat == S_AOK)) ? S_INS : p.E_stat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else if (set_cc) begin
            cc_q <= {zf, sf, of};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else if (p.M_stall) begin
            m_stat_q  <= m_stat_q;
        end else if (p.M_bubble) begin
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            m_stat_q  <= stat_eff;
            m_icode_q <= p.E_icode;
            m_cnd_q   <= cnd;
            m_vale_q  <= res;
            m_vala_q  <= p.E_valA;
            m_dste_q  <= dste_eff;
            m_dstm_q  <= p.E_dstM;
        end
    end

    assign p.e_valE  = res;
    assign p.e_dstE  = dste_eff;
    assign p.cc      = cc_q;
    assign p.M_stat  = m_stat_q;
    assign p.M_icode = m_icode_q;
    assign p.M_Cnd   = m_cnd_q;
    assign p.M_valE  = m_vale_q;
    assign p.M_valA  = m_vala_q;
    assign p.M_dstE  = m_dste_q;
    assign p.M_dstM  = m_dstm_q;
endmodule
